// File: rtl/piso_serializer_8_if.sv
// Word-side handshake and serial-side bus of piso_serializer_8.
// The master drives words and the bit-rate enable; the slave is the serializer.
interface piso_serializer_8_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       ser_en;
   logic       ser_out;
   logic       ser_valid;
   logic [2:0] sel;
   logic       frame_start;
   logic       frame_done;
   logic       busy;

   modport master (
      output in_data, in_valid, ser_en,
      input  in_ready, ser_out, ser_valid, sel, frame_start, frame_done, busy
   );

   modport slave (
      input  in_data, in_valid, ser_en,
      output in_ready, ser_out, ser_valid, sel, frame_start, frame_done, busy
   );
endinterface

// File: rtl/piso_serializer_8.sv
// Parallel-in/serial-out front end: one active word plus one buffered word,
// a 3-bit counter driving an 8:1 bit select, gap-free framed output.
module piso_serializer_8 #(
   parameter bit LSB_FIRST = 1'b1
) (
   input logic                 clk,
   input logic                 rst,
   piso_serializer_8_if.slave  bus
);

   typedef enum logic [0:0] {StIdle, StShift} state_e;

   state_e     state_q;
   logic [2:0] cnt_q;
   logic [7:0] cur_q;
   logic [7:0] hold_q;
   logic       hold_full_q;

   logic       shifting;
   logic       accept;
   logic       last_bit;

   assign shifting = (state_q == StShift);
   assign accept   = bus.in_valid && !hold_full_q;
   assign last_bit = shifting && bus.ser_en && (cnt_q == 3'd7);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= 3'd0;
         cur_q       <= 8'd0;
         hold_q      <= 8'd0;
         hold_full_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (accept) begin
                  cur_q   <= bus.in_data;
                  cnt_q   <= 3'd0;
                  state_q <= StShift;
               end
            end
            StShift: begin
               if (last_bit) begin
                  cnt_q <= 3'd0;
                  // Buffered word wins over a new input; in_ready is low then anyway.
                  if (hold_full_q) begin
                     cur_q       <= hold_q;
                     hold_full_q <= 1'b0;
                  end else if (accept) begin
                     cur_q <= bus.in_data;
                  end else begin
                     state_q <= StIdle;
                  end
               end else begin
                  if (bus.ser_en) begin
                     cnt_q <= cnt_q + 3'd1;
                  end
                  if (accept) begin
                     hold_q      <= bus.in_data;
                     hold_full_q <= 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.in_ready    = !hold_full_q;
   assign bus.sel         = LSB_FIRST ? cnt_q : (3'd7 - cnt_q);
   assign bus.ser_out     = shifting ? cur_q[bus.sel] : 1'b0;
   assign bus.ser_valid   = shifting;
   assign bus.frame_start = shifting && (cnt_q == 3'd0);
   assign bus.frame_done  = last_bit;
   assign bus.busy        = shifting || hold_full_q;

endmodule

// File: tb/tb_piso_serializer_8.sv
// Bench for piso_serializer_8: LSB-first and MSB-first instances share stimulus,
// a scoreboard queue holds the expected bit stream and a negedge monitor checks it.
module tb_piso_serializer_8;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] in_data = 8'd0;
   logic       in_valid = 1'b0;
   logic       ser_en = 1'b1;

   always #5 clk = ~clk;

   piso_serializer_8_if bus_a ();
   piso_serializer_8_if bus_b ();

   assign bus_a.in_data  = in_data;
   assign bus_a.in_valid = in_valid;
   assign bus_a.ser_en   = ser_en;
   assign bus_b.in_data  = in_data;
   assign bus_b.in_valid = in_valid;
   assign bus_b.ser_en   = ser_en;

   piso_serializer_8 #(.LSB_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
   piso_serializer_8 #(.LSB_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

   typedef struct packed {
      logic       ba;
      logic [2:0] sa;
      logic       bb;
      logic [2:0] sb;
      logic       first;
      logic       last;
   } ent_t;

   ent_t       sb_q[$];
   ent_t       e;
   int         checks = 0;
   int         errors = 0;
   int         valid_cycles = 0;
   int         valid_rises = 0;
   int         fd_pulses = 0;
   int         nr_cycles = 0;
   logic       prev_valid = 1'b0;
   logic [7:0] cap_a = 8'd0;
   logic [7:0] cap_b = 8'd0;
   bit         stall_mode = 1'b0;
   int         pc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic push_word(input logic [7:0] w);
      ent_t n;
      for (int i = 0; i < 8; i++) begin
         n.ba    = w[i];
         n.sa    = i[2:0];
         n.bb    = w[7-i];
         n.sb    = 3'(7 - i);
         n.first = (i == 0);
         n.last  = (i == 7);
         sb_q.push_back(n);
      end
   endtask

   // Offers a word until accepted; in_ready is stable between negedge and the next edge.
   task automatic send(input logic [7:0] w, input bit keep);
      bit done = 1'b0;
      in_data  = w;
      in_valid = 1'b1;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         done = bus_a.in_ready;
         @(posedge clk);
         #1;
      end
      if (done) push_word(w);
      else begin
         checks++;
         errors++;
         $display("FAIL send_timeout: word %0h not accepted, expected acceptance", w);
      end
      if (!keep) in_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      bit idle = 1'b0;
      for (int n = 0; n < budget && !idle; n++) begin
         @(negedge clk);
         idle = !bus_a.ser_valid && !bus_a.busy;
      end
      if (!idle) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: still busy after %0d cycles, expected idle", budget);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_in_ready"}, {bus_a.in_ready, bus_b.in_ready}, 2'b11);
      check({tag, "_ser_valid"}, {bus_a.ser_valid, bus_b.ser_valid}, 2'b00);
      check({tag, "_ser_out"}, {bus_a.ser_out, bus_b.ser_out}, 2'b00);
      check({tag, "_busy"}, {bus_a.busy, bus_b.busy}, 2'b00);
      check({tag, "_sel_a"}, bus_a.sel, 3'd0);
      check({tag, "_sel_b"}, bus_b.sel, 3'd7);
      check({tag, "_frame"}, {bus_a.frame_start, bus_a.frame_done,
                              bus_b.frame_start, bus_b.frame_done}, 4'b0000);
   endtask

   initial forever begin
      @(posedge clk);
      #1;
      ser_en = stall_mode ? (pc % 3 == 0) : 1'b1;
      pc++;
   end

   // Monitor: pending scoreboard entries mean the DUTs must be shifting the head bit.
   initial forever begin
      @(negedge clk);
      check("ser_valid_a", bus_a.ser_valid, sb_q.size() != 0);
      check("ser_valid_b", bus_b.ser_valid, sb_q.size() != 0);
      if (sb_q.size() != 0 && bus_a.ser_valid) begin
         e = sb_q[0];
         check("ser_out_a", bus_a.ser_out, e.ba);
         check("sel_a", bus_a.sel, e.sa);
         check("ser_out_b", bus_b.ser_out, e.bb);
         check("sel_b", bus_b.sel, e.sb);
         check("frame_start", {bus_a.frame_start, bus_b.frame_start}, {2{e.first}});
         check("frame_done", {bus_a.frame_done, bus_b.frame_done}, {2{ser_en && e.last}});
         if (ser_en) begin
            cap_a = {cap_a[6:0], bus_a.ser_out};
            cap_b = {cap_b[6:0], bus_b.ser_out};
            void'(sb_q.pop_front());
         end
      end else if (!bus_a.ser_valid) begin
         check("idle_out", {bus_a.ser_out, bus_a.frame_start, bus_a.frame_done,
                            bus_b.ser_out, bus_b.frame_start, bus_b.frame_done}, 6'd0);
      end
      if (bus_a.ser_valid) valid_cycles++;
      if (bus_a.ser_valid && !prev_valid) valid_rises++;
      if (bus_a.frame_done) fd_pulses++;
      if (!bus_a.in_ready) nr_cycles++;
      prev_valid = bus_a.ser_valid;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Asynchronous reset between edges takes effect without a clock.
      #3 rst = 1'b1;
      #1 check_idle("reset");
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end

      // Single word 8'hC1: stream 1,0,0,0,0,0,1,1 (LSB) and 1,1,0,0,0,0,0,1 (MSB).
      cap_a = 8'd0;
      cap_b = 8'd0;
      send(8'hC1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("t2_valid", bus_a.ser_valid, 1'b1);
         if (i == 0) check("t2_first_start", bus_a.frame_start, 1'b1);
         if (i == 7) check("t2_last_done", bus_a.frame_done, 1'b1);
      end
      @(negedge clk);
      check("t2_idle_9th", bus_a.ser_valid, 1'b0);
      #1;
      check("t2_stream_lsb", cap_a, 8'h83);
      check("t2_stream_msb", cap_b, 8'hC1);
      @(posedge clk);
      #1;

      // Back-to-back 01, 80, FF with in_valid held high.
      valid_cycles = 0;
      valid_rises = 0;
      fd_pulses = 0;
      nr_cycles = 0;
      send(8'h01, 1'b1);
      send(8'h80, 1'b1);
      send(8'hFF, 1'b0);
      wait_idle(100);
      check("t4_valid_cycles", valid_cycles, 24);
      check("t4_valid_rises", valid_rises, 1);
      check("t4_frame_done", fd_pulses, 3);
      check("t4_not_ready", nr_cycles, 14);

      // Stalled consumer: ser_en = 1,0,0,1,0,0,...
      fd_pulses = 0;
      cap_a = 8'd0;
      cap_b = 8'd0;
      stall_mode = 1'b1;
      send(8'hC1, 1'b0);
      wait_idle(100);
      stall_mode = 1'b0;
      check("t5_stream_lsb", cap_a, 8'h83);
      check("t5_stream_msb", cap_b, 8'hC1);
      check("t5_frame_done", fd_pulses, 1);

      // Reset after 3 bits of C1 with 55 buffered.
      send(8'hC1, 1'b1);
      send(8'h55, 1'b0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      check("t6_busy", bus_a.busy, 1'b1);
      check("t6_hold_full", bus_a.in_ready, 1'b0);
      #2 rst = 1'b1;
      #1 check_idle("midreset");
      sb_q.delete();
      fd_pulses = 0;
      @(posedge clk);
      #1 rst = 1'b0;
      cap_a = 8'd0;
      cap_b = 8'd0;
      send(8'h0F, 1'b0);
      wait_idle(100);
      check("t6_stream_lsb", cap_a, 8'hF0);
      check("t6_stream_msb", cap_b, 8'h0F);
      check("t6_frame_done", fd_pulses, 1);

      check("queue_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
